// File: rtl/tophat_infer_ctrl.sv
// tophat_infer_ctrl: host command sequencer for the tophat tree engine.
// Parses host bytes into clear/load/infer commands, forwards model
// payload to the loader, captures features and walks the tree.
// Ports:
//   clk, rst            clock, async active-high reset
//   host_valid_i/byte_i host byte stream, one byte per strobe
//   busy_o              high while a command is in progress
//   load_clear_o        one-cycle clear pulse to the model loader
//   load_valid_o/byte_o payload byte to the model loader
//   model_loaded_i      loader holds a complete model
//   node_*_i, leaf_*_i  flattened model tables from the loader
//   result_o/valid_o    leaf value of the last inference, pulse on update
//   error_o             sticky error, cleared by the next good command
// Node, leaf and feature indexes are 3 bits wide, so the tables are
// padded to 8 entries internally; padding entries are never selected.
module tophat_infer_ctrl #(
  parameter int         NUM_INTERNAL = 7,
  parameter int         NUM_LEAVES   = 8,
  parameter int         NUM_FEATURES = 8,
  parameter logic [7:0] CMD_CLEAR    = 8'hA0,
  parameter logic [7:0] CMD_LOAD     = 8'hA1,
  parameter logic [7:0] CMD_INFER    = 8'hA2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_valid_i,
  input  logic [7:0]                host_byte_i,
  output logic                      busy_o,
  output logic                      load_clear_o,
  output logic                      load_valid_o,
  output logic [7:0]                load_byte_o,
  input  logic                      model_loaded_i,
  input  logic [NUM_INTERNAL*3-1:0] node_feature_i,
  input  logic [NUM_INTERNAL*8-1:0] node_threshold_i,
  input  logic [NUM_INTERNAL*4-1:0] node_left_i,
  input  logic [NUM_INTERNAL*4-1:0] node_right_i,
  input  logic [NUM_LEAVES*8-1:0]   leaf_value_i,
  output logic [7:0]                result_o,
  output logic                      result_valid_o,
  output logic                      error_o
);

  localparam int MODEL_BYTES = NUM_INTERNAL*4 + NUM_LEAVES;
  localparam int IDX_N       = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FEAT,
    WALK
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  node_q, node_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  feat_q [IDX_N];
  logic        feat_we;
  logic        clear_q, clear_d;
  logic        lvalid_q, lvalid_d;
  logic [7:0]  lbyte_q, lbyte_d;
  logic [7:0]  res_q, res_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;

  logic [2:0]  nf_a [IDX_N];
  logic [7:0]  nt_a [IDX_N];
  logic [3:0]  nl_a [IDX_N];
  logic [3:0]  nr_a [IDX_N];
  logic [7:0]  lv_a [IDX_N];

  for (genvar g = 0; g < IDX_N; g++) begin : g_node
    if (g < NUM_INTERNAL) begin : g_v
      assign nf_a[g] = node_feature_i[g*3 +: 3];
      assign nt_a[g] = node_threshold_i[g*8 +: 8];
      assign nl_a[g] = node_left_i[g*4 +: 4];
      assign nr_a[g] = node_right_i[g*4 +: 4];
    end else begin : g_z
      assign nf_a[g] = '0;
      assign nt_a[g] = '0;
      assign nl_a[g] = '0;
      assign nr_a[g] = '0;
    end
  end

  for (genvar g = 0; g < IDX_N; g++) begin : g_leaf
    if (g < NUM_LEAVES) begin : g_v
      assign lv_a[g] = leaf_value_i[g*8 +: 8];
    end else begin : g_z
      assign lv_a[g] = '0;
    end
  end

  logic [7:0] f_val;
  logic       go_left;
  logic [3:0] child;
  logic [2:0] c_idx;
  logic       c_leaf;
  logic       leaf_ok;
  logic       node_ok;

  // Child code: bit3 selects a leaf, bits 2:0 index it.
  assign f_val   = feat_q[nf_a[node_q]];
  assign go_left = f_val <= nt_a[node_q];
  assign child   = go_left ? nl_a[node_q] : nr_a[node_q];
  assign c_leaf  = child[3];
  assign c_idx   = child[2:0];
  assign leaf_ok = {29'd0, c_idx} < 32'(NUM_LEAVES);
  assign node_ok = {29'd0, c_idx} < 32'(NUM_INTERNAL);

  logic is_clr, is_load, is_inf;

  assign is_clr  = host_byte_i == CMD_CLEAR;
  assign is_load = host_byte_i == CMD_LOAD;
  assign is_inf  = host_byte_i == CMD_INFER;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    node_d   = node_q;
    step_d   = step_q;
    feat_we  = 1'b0;
    clear_d  = 1'b0;
    lvalid_d = 1'b0;
    lbyte_d  = lbyte_q;
    res_d    = res_q;
    rv_d     = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (host_valid_i) begin
          unique case (1'b1)
            is_clr: begin
              clear_d = 1'b1;
              err_d   = 1'b0;
            end
            is_load: begin
              clear_d = 1'b1;
              err_d   = 1'b0;
              cnt_d   = '0;
              state_d = LOAD;
            end
            is_inf && model_loaded_i: begin
              err_d   = 1'b0;
              cnt_d   = '0;
              state_d = FEAT;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      LOAD: begin
        if (host_valid_i) begin
          lvalid_d = 1'b1;
          lbyte_d  = host_byte_i;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == 6'(MODEL_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      FEAT: begin
        if (host_valid_i) begin
          feat_we = 1'b1;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'(NUM_FEATURES - 1)) begin
            cnt_d   = '0;
            node_d  = '0;
            step_d  = '0;
            state_d = WALK;
          end
        end
      end
      WALK: begin
        // Stray host bytes are dropped; the walk still completes.
        if (host_valid_i) err_d = 1'b1;
        if (c_leaf) begin
          state_d = IDLE;
          if (leaf_ok) begin
            res_d = lv_a[c_idx];
            rv_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (!node_ok) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (step_q == 3'(NUM_INTERNAL - 1)) begin
          // A legal tree never needs more internal steps than nodes.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          node_d = c_idx;
          step_d = step_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      node_q   <= '0;
      step_q   <= '0;
      clear_q  <= 1'b0;
      lvalid_q <= 1'b0;
      lbyte_q  <= '0;
      res_q    <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < IDX_N; i++) feat_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      node_q   <= node_d;
      step_q   <= step_d;
      clear_q  <= clear_d;
      lvalid_q <= lvalid_d;
      lbyte_q  <= lbyte_d;
      res_q    <= res_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      if (feat_we) feat_q[cnt_q[2:0]] <= host_byte_i;
    end
  end

  assign busy_o         = state_q != IDLE;
  assign load_clear_o   = clear_q;
  assign load_valid_o   = lvalid_q;
  assign load_byte_o    = lbyte_q;
  assign result_o       = res_q;
  assign result_valid_o = rv_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_tophat_infer_ctrl.sv
// tb_tophat_infer_ctrl: randomized bench for tophat_infer_ctrl with a
// behavioural model loader and a reference tree walker.
module tb_tophat_infer_ctrl;

  localparam int NI = 7;
  localparam int NL = 8;
  localparam int NB = NI*4 + NL;

  logic             clk = 1'b0;
  logic             rst;
  logic             host_valid;
  logic [7:0]       host_byte;
  logic             busy_o;
  logic             load_clear_o;
  logic             load_valid_o;
  logic [7:0]       load_byte_o;
  logic             model_loaded;
  logic [NI*3-1:0]  node_feature;
  logic [NI*8-1:0]  node_threshold;
  logic [NI*4-1:0]  node_left;
  logic [NI*4-1:0]  node_right;
  logic [NL*8-1:0]  leaf_value;
  logic [7:0]       result_o;
  logic             result_valid_o;
  logic             error_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mdl [NB];
  logic [7:0] ftr [8];
  logic [7:0] mem [NB];
  int         ld_cnt;
  logic [7:0] last_result;

  tophat_infer_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .host_valid_i     (host_valid),
    .host_byte_i      (host_byte),
    .busy_o           (busy_o),
    .load_clear_o     (load_clear_o),
    .load_valid_o     (load_valid_o),
    .load_byte_o      (load_byte_o),
    .model_loaded_i   (model_loaded),
    .node_feature_i   (node_feature),
    .node_threshold_i (node_threshold),
    .node_left_i      (node_left),
    .node_right_i     (node_right),
    .leaf_value_i     (leaf_value),
    .result_o         (result_o),
    .result_valid_o   (result_valid_o),
    .error_o          (error_o)
  );

  always #5 clk = ~clk;

  // Model loader: bytes 4i..4i+3 are node i feature, threshold,
  // left, right; the last NL bytes are the leaf values.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt       <= 0;
      model_loaded <= 1'b0;
    end else if (load_clear_o) begin
      ld_cnt       <= 0;
      model_loaded <= 1'b0;
    end else if (load_valid_o && ld_cnt < NB) begin
      mem[ld_cnt] <= load_byte_o;
      ld_cnt      <= ld_cnt + 1;
      if (ld_cnt == NB - 1) model_loaded <= 1'b1;
    end
  end

  for (genvar g = 0; g < NI; g++) begin : g_n
    assign node_feature[g*3 +: 3]   = mem[4*g][2:0];
    assign node_threshold[g*8 +: 8] = mem[4*g+1];
    assign node_left[g*4 +: 4]      = mem[4*g+2][3:0];
    assign node_right[g*4 +: 4]     = mem[4*g+3][3:0];
  end
  for (genvar g = 0; g < NL; g++) begin : g_l
    assign leaf_value[g*8 +: 8] = mem[NI*4+g];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference walk over the intended model: number of nodes visited,
  // error flag and leaf value.
  function automatic void ref_walk(output int steps, output bit err,
                                   output logic [7:0] val);
    int node = 0;
    int fi, idx, code;
    err = 1'b0;
    val = '0;
    steps = 0;
    for (int s = 1; s <= NI; s++) begin
      fi = int'(mdl[4*node]) % 8;
      if (ftr[fi] <= mdl[4*node+1]) code = int'(mdl[4*node+2]);
      else code = int'(mdl[4*node+3]);
      steps = s;
      idx = code % 8;
      if ((code / 8) % 2 == 1) begin
        if (idx >= NL) err = 1'b1;
        else val = mdl[NI*4+idx];
        return;
      end
      if (idx >= NI) begin
        err = 1'b1;
        return;
      end
      node = idx;
    end
    err = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] b);
    host_valid = 1'b1;
    host_byte  = b;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic load_model();
    host_valid = 1'b1;
    host_byte  = 8'hA1;
    tick();
    check("ld_clear", load_clear_o, 1);
    check("ld_busy", busy_o, 1);
    for (int i = 0; i < NB; i++) begin
      host_byte = mdl[i];
      tick();
      check("ld_byte", {load_valid_o, load_byte_o}, {1'b1, mdl[i]});
    end
    host_valid = 1'b0;
    check("ld_done", busy_o, 0);
    tick();
    check("ld_vdrop", load_valid_o, 0);
    tick();
  endtask

  task automatic run_infer(input bit inject);
    int steps, pulses, pcyc, done_cyc;
    bit err;
    logic [7:0] val, pval;
    ref_walk(steps, err, val);
    host_valid = 1'b1;
    host_byte  = 8'hA2;
    tick();
    check("inf_busy", busy_o, 1);
    check("inf_eclr", error_o, 0);
    for (int i = 0; i < 8; i++) begin
      host_byte = ftr[i];
      tick();
    end
    host_valid = 1'b0;
    pulses = 0;
    pcyc = 0;
    done_cyc = 0;
    pval = '0;
    for (int k = 1; k <= NI + 2; k++) begin
      if (k == 1 && inject) begin
        host_valid = 1'b1;
        host_byte  = 8'h55;
      end
      tick();
      host_valid = 1'b0;
      if (result_valid_o) begin
        pulses++;
        pcyc = k;
        pval = result_o;
      end
      if (!busy_o && done_cyc == 0) done_cyc = k;
    end
    if (!err) begin
      check("inf_pulses", pulses, 1);
      check("inf_lat", pcyc, steps);
      check("inf_val", pval, val);
      last_result = val;
    end else begin
      check("inf_nopulse", pulses, 0);
    end
    check("inf_done", done_cyc, steps);
    check("inf_err", error_o, err | inject);
    check("inf_hold", result_o, last_result);
  endtask

  function automatic logic [7:0] rand_child(input int i);
    int r = $urandom_range(0, 9);
    if (r < 4 || i == NI - 1) return 8'(8 + $urandom_range(0, 7));
    if (r < 9) return 8'($urandom_range(i + 1, NI - 1));
    if ($urandom_range(0, 1) == 1) return 8'd7;
    return 8'(i);
  endfunction

  task automatic gen_model();
    for (int i = 0; i < NI; i++) begin
      mdl[4*i]   = 8'($urandom_range(0, 7));
      mdl[4*i+1] = 8'($urandom);
      mdl[4*i+2] = rand_child(i);
      mdl[4*i+3] = rand_child(i);
    end
    for (int i = 0; i < NL; i++) mdl[NI*4+i] = 8'($urandom);
  endtask

  // Base model: every node points at leaf 0/1, leaves 11,22,..,88.
  task automatic base_model();
    for (int i = 0; i < NI; i++) begin
      mdl[4*i]   = 8'd0;
      mdl[4*i+1] = 8'd0;
      mdl[4*i+2] = 8'd8;
      mdl[4*i+3] = 8'd9;
    end
    for (int i = 0; i < NL; i++) mdl[NI*4+i] = 8'((i + 1) * 8'h11);
    mdl[0] = 8'd2;
    mdl[1] = 8'd40;
  endtask

  task automatic rand_feats();
    for (int i = 0; i < 8; i++) ftr[i] = 8'($urandom);
  endtask

  initial begin
    last_result = '0;
    rst        = 1'b1;
    host_valid = 1'b1;
    host_byte  = 8'hA1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {busy_o, load_clear_o, load_valid_o, load_byte_o,
                      result_o, result_valid_o, error_o}, 0);
    host_valid = 1'b0;
    rst = 1'b0;
    tick();

    send1(8'hA2);
    check("nomodel_err", error_o, 1);
    check("nomodel_idle", busy_o, 0);
    send1(8'hA0);
    check("clr_eclr", error_o, 0);
    check("clr_pulse", load_clear_o, 1);
    tick();
    check("clr_drop", load_clear_o, 0);
    send1(8'h37);
    check("badcmd_err", error_o, 1);

    base_model();
    load_model();
    rand_feats();
    ftr[2] = 8'd40;
    run_infer(1'b0);
    check("leaf0_val", result_o, 8'h11);
    ftr[2] = 8'd41;
    run_infer(1'b0);
    check("leaf1_val", result_o, 8'h22);

    base_model();
    mdl[0] = 8'd0; mdl[1] = 8'h80; mdl[2] = 8'd1; mdl[3] = 8'd8;
    mdl[4] = 8'd1; mdl[5] = 8'h80; mdl[6] = 8'd3; mdl[7] = 8'd9;
    mdl[12] = 8'd4; mdl[13] = 8'h10; mdl[14] = 8'd13; mdl[15] = 8'd10;
    mdl[NI*4+5] = 8'h5A;
    load_model();
    rand_feats();
    ftr[0] = 8'h10; ftr[1] = 8'h20; ftr[4] = 8'h05;
    run_infer(1'b0);
    check("depth3_val", result_o, 8'h5A);
    run_infer(1'b1);

    base_model();
    mdl[2] = 8'd0;
    mdl[3] = 8'd0;
    load_model();
    rand_feats();
    run_infer(1'b0);

    for (int it = 0; it < 30; it++) begin
      if (it % 4 == 0) begin
        gen_model();
        load_model();
      end
      rand_feats();
      run_infer($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    host_valid = 1'b1;
    host_byte  = 8'hA1;
    tick();
    for (int i = 0; i < 10; i++) begin
      host_byte = 8'(i);
      tick();
    end
    rst = 1'b1;
    host_valid = 1'b0;
    #1;
    check("midrst_out", {busy_o, load_clear_o, load_valid_o, result_o,
                         result_valid_o, error_o}, 0);
    tick();
    rst = 1'b0;
    tick();
    send1(8'hA2);
    check("midrst_noload", error_o, 1);
    check("midrst_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
